// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + dividend/divisor
// in; out_valid/out_ready + quotient/remainder/div_zero out.
module seq_restoring_divider #(
    parameter int DVD_W = 16,
    parameter int DVS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = (DVD_W > 1) ? $clog2(DVD_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DVD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    // Partial remainder: the restored value is always below the
    // divisor, so only DVS_W bits need storing between steps.
    logic [DVS_W-1:0] p;
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] dvs;
    logic [CW-1:0]    count;

    logic [DVS_W:0]   t;
    logic [DVS_W-1:0] diff;
    logic             ge;
    logic [DVS_W-1:0] p_nxt;
    logic [DVD_W-1:0] q_nxt;

    // One restoring step on the (DVS_W+1)-bit trial value.
    // When t >= dvs the true difference is < dvs, so the low
    // DVS_W bits of the subtraction are exact.
    always_comb begin
        t     = {p, q[DVD_W-1]};
        ge    = (t >= {1'b0, dvs});
        diff  = t[DVS_W-1:0] - dvs;
        p_nxt = ge ? diff : t[DVS_W-1:0];
        q_nxt = {q[DVD_W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            count     <= '0;
            p         <= '0;
            q         <= '0;
            dvs       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            state     <= DONE;
                            quotient  <= '1;
                            remainder <= dividend[DVS_W-1:0];
                            div_zero  <= 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                            dvs   <= divisor;
                            p     <= '0;
                            q     <= dividend;
                            count <= '0;
                        end
                    end
                end
                RUN: begin
                    p     <= p_nxt;
                    q     <= q_nxt;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        quotient  <= q_nxt;
                        remainder <= p_nxt;
                        div_zero  <= 1'b0;
                        out_valid <= 1'b1;
                        count     <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
